// File: rtl/taxi_axil_rd_arb.sv
// taxi_axil_rd_arb
// ----------------
// S_COUNT-to-1 AXI4-lite read arbiter. Several AXI-lite read masters share one
// downstream AXI-lite read port. Only one read is in flight at a time; the
// accepted AR beat is held in registers and replayed downstream, and the R
// beat is routed back to the granted requester only.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   s_axil_ar*_i/_o        upstream AR channels, concatenated per port
//                          (port i occupies slice [i*W +: W])
//   s_axil_r*_o / rready_i upstream R channels; rdata/rresp/ruser broadcast,
//                          rvalid gated to the granted port
//   m_axil_ar*_o/arready_i downstream AR channel (registered)
//   m_axil_r*_i / rready_o downstream R channel
//   busy_o                 high while a grant is held (AR or R)
//   grant_idx_o            index of the current or most recent grant
module taxi_axil_rd_arb #(
  parameter int S_COUNT               = 4,
  parameter int ARB_ROUND_ROBIN       = 1,
  parameter int ARB_LSB_HIGH_PRIORITY = 1,
  parameter int DATA_W                = 32,
  parameter int ADDR_W                = 32,
  parameter int STRB_W                = DATA_W / 8,
  parameter int M_DATA_W              = DATA_W,
  parameter int M_ADDR_W              = ADDR_W,
  parameter int M_STRB_W              = STRB_W,
  parameter int S_ARUSER_EN           = 0,
  parameter int M_ARUSER_EN           = 0,
  parameter int ARUSER_W              = 1,
  parameter int S_RUSER_EN            = 0,
  parameter int M_RUSER_EN            = 0,
  parameter int RUSER_W               = 1,
  localparam int IDX_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,

  input  logic [S_COUNT*ADDR_W-1:0]     s_axil_araddr_i,
  input  logic [S_COUNT*3-1:0]          s_axil_arprot_i,
  input  logic [S_COUNT*ARUSER_W-1:0]   s_axil_aruser_i,
  input  logic [S_COUNT-1:0]            s_axil_arvalid_i,
  output logic [S_COUNT-1:0]            s_axil_arready_o,
  output logic [S_COUNT*DATA_W-1:0]     s_axil_rdata_o,
  output logic [S_COUNT*2-1:0]          s_axil_rresp_o,
  output logic [S_COUNT*RUSER_W-1:0]    s_axil_ruser_o,
  output logic [S_COUNT-1:0]            s_axil_rvalid_o,
  input  logic [S_COUNT-1:0]            s_axil_rready_i,

  output logic [M_ADDR_W-1:0]           m_axil_araddr_o,
  output logic [2:0]                    m_axil_arprot_o,
  output logic [ARUSER_W-1:0]           m_axil_aruser_o,
  output logic                          m_axil_arvalid_o,
  input  logic                          m_axil_arready_i,
  input  logic [M_DATA_W-1:0]           m_axil_rdata_i,
  input  logic [1:0]                    m_axil_rresp_i,
  input  logic [RUSER_W-1:0]            m_axil_ruser_i,
  input  logic                          m_axil_rvalid_i,
  output logic                          m_axil_rready_o,

  output logic                          busy_o,
  output logic [IDX_W-1:0]              grant_idx_o
);

  // Configuration checks
  if (S_COUNT < 1 || S_COUNT > 16) begin : g_bad_count
    $fatal(1, "taxi_axil_rd_arb: S_COUNT must be in 1..16");
  end
  if (M_DATA_W != DATA_W) begin : g_bad_data_w
    $fatal(1, "taxi_axil_rd_arb: DATA_W mismatch between s and m");
  end
  if (M_ADDR_W != ADDR_W) begin : g_bad_addr_w
    $fatal(1, "taxi_axil_rd_arb: ADDR_W mismatch between s and m");
  end
  if (M_STRB_W != STRB_W) begin : g_bad_strb_w
    $fatal(1, "taxi_axil_rd_arb: STRB_W mismatch between s and m");
  end

  // USER sidebands travel only when both sides carry them.
  localparam bit ARUSER_FWD = (S_ARUSER_EN != 0) && (M_ARUSER_EN != 0);
  localparam bit RUSER_FWD  = (S_RUSER_EN != 0) && (M_RUSER_EN != 0);

  localparam logic [IDX_W-1:0] FIXED_BASE =
    (ARB_LSB_HIGH_PRIORITY != 0) ? '0 : IDX_W'(S_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [ADDR_W-1:0]     araddr_q, araddr_d;
  logic [2:0]            arprot_q, arprot_d;
  logic [ARUSER_W-1:0]   aruser_q, aruser_d;

  // Per-port views of the concatenated AR fields.
  logic [ADDR_W-1:0]     s_araddr [S_COUNT];
  logic [2:0]            s_arprot [S_COUNT];
  logic [ARUSER_W-1:0]   s_aruser [S_COUNT];

  for (genvar i = 0; i < S_COUNT; i++) begin : g_unpack
    assign s_araddr[i] = s_axil_araddr_i[i*ADDR_W +: ADDR_W];
    assign s_arprot[i] = s_axil_arprot_i[i*3 +: 3];
    assign s_aruser[i] = s_axil_aruser_i[i*ARUSER_W +: ARUSER_W];
  end

  // k-th index in priority order starting from base: ascending when the LSB
  // has priority, descending otherwise, wrapping modulo S_COUNT.
  function automatic logic [IDX_W-1:0] prio_idx(input logic [IDX_W-1:0] base,
                                                input int k);
    int b;
    b = int'(base);
    if (ARB_LSB_HIGH_PRIORITY != 0) begin
      return IDX_W'((b + k) % S_COUNT);
    end
    return IDX_W'((b + S_COUNT - k) % S_COUNT);
  endfunction

  // Winner search. Fixed priority always scans from the top-priority end;
  // round-robin scans from the pointer.
  logic [IDX_W-1:0] sel_base;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] cand;
  logic             sel_found;

  assign sel_base = (ARB_ROUND_ROBIN != 0) ? ptr_q : FIXED_BASE;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < S_COUNT; k++) begin
      cand = prio_idx(sel_base, k);
      if (!sel_found && s_axil_arvalid_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  logic rready_sel;
  assign rready_sel = s_axil_rready_i[grant_q];

  // Next-state and upstream AR handshake
  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    ptr_d            = ptr_q;
    araddr_d         = araddr_q;
    arprot_d         = arprot_q;
    aruser_d         = aruser_q;
    s_axil_arready_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          // arready is only ever raised here, so the winner is accepted
          // exactly once and the held copy is what goes downstream.
          s_axil_arready_o[sel_idx] = 1'b1;
          grant_d  = sel_idx;
          araddr_d = s_araddr[sel_idx];
          arprot_d = s_arprot[sel_idx];
          aruser_d = s_aruser[sel_idx];
          state_d  = ST_AR;
        end
      end
      ST_AR: begin
        if (m_axil_arready_i) begin
          state_d = ST_R;
        end
      end
      ST_R: begin
        if (m_axil_rvalid_i && rready_sel) begin
          state_d = ST_IDLE;
          if (ARB_ROUND_ROBIN != 0) begin
            ptr_d = prio_idx(grant_q, 1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
      araddr_q <= '0;
      arprot_q <= '0;
      aruser_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      araddr_q <= araddr_d;
      arprot_q <= arprot_d;
      aruser_q <= aruser_d;
    end
  end

  // Downstream AR replays the held beat
  assign m_axil_arvalid_o = (state_q == ST_AR);
  assign m_axil_araddr_o  = araddr_q;
  assign m_axil_arprot_o  = arprot_q;
  assign m_axil_aruser_o  = ARUSER_FWD ? aruser_q : '0;

  // R channel: payload broadcast, handshake confined to the granted port
  assign m_axil_rready_o = (state_q == ST_R) && rready_sel;

  always_comb begin
    s_axil_rvalid_o = '0;
    if (state_q == ST_R) begin
      s_axil_rvalid_o[grant_q] = m_axil_rvalid_i;
    end
  end

  assign s_axil_rdata_o = {S_COUNT{m_axil_rdata_i}};
  assign s_axil_rresp_o = {S_COUNT{m_axil_rresp_i}};
  assign s_axil_ruser_o = RUSER_FWD ? {S_COUNT{m_axil_ruser_i}} : '0;

  assign busy_o      = (state_q != ST_IDLE);
  assign grant_idx_o = grant_q;

endmodule

// File: tb/tb_taxi_axil_rd_arb.sv
// Bench for taxi_axil_rd_arb. Three instances share one stimulus:
//   a_* : round-robin, LSB priority, USER enabled upstream only (gated)
//   f_* : fixed priority, LSB high, USER enabled on both sides
//   g_* : fixed priority, MSB high
module tb_taxi_axil_rd_arb;

  logic          clk;
  logic          rst_n;

  logic [127:0]  s_araddr;
  logic [11:0]   s_arprot;
  logic [15:0]   s_aruser;
  logic [3:0]    s_arvalid;
  logic [3:0]    s_rready;
  logic          m_arready;
  logic [31:0]   m_rdata;
  logic [1:0]    m_rresp;
  logic [3:0]    m_ruser;
  logic          m_rvalid;

  logic [3:0]    a_s_arready, f_s_arready, g_s_arready;
  logic [127:0]  a_s_rdata, f_s_rdata, g_s_rdata;
  logic [7:0]    a_s_rresp, f_s_rresp, g_s_rresp;
  logic [15:0]   a_s_ruser, f_s_ruser, g_s_ruser;
  logic [3:0]    a_s_rvalid, f_s_rvalid, g_s_rvalid;
  logic [31:0]   a_m_araddr, f_m_araddr, g_m_araddr;
  logic [2:0]    a_m_arprot, f_m_arprot, g_m_arprot;
  logic [3:0]    a_m_aruser, f_m_aruser, g_m_aruser;
  logic          a_m_arvalid, f_m_arvalid, g_m_arvalid;
  logic          a_m_rready, f_m_rready, g_m_rready;
  logic          a_busy, f_busy, g_busy;
  logic [1:0]    a_grant, f_grant, g_grant;

  int checks = 0;
  int errors = 0;

  int q_rr[$];
  int q_f[$];
  int q_g[$];

  taxi_axil_rd_arb #(
    .S_COUNT(4), .ARB_ROUND_ROBIN(1), .ARB_LSB_HIGH_PRIORITY(1),
    .S_ARUSER_EN(1), .M_ARUSER_EN(0), .ARUSER_W(4),
    .S_RUSER_EN(1), .M_RUSER_EN(0), .RUSER_W(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_axil_araddr_i(s_araddr), .s_axil_arprot_i(s_arprot),
    .s_axil_aruser_i(s_aruser), .s_axil_arvalid_i(s_arvalid),
    .s_axil_arready_o(a_s_arready), .s_axil_rdata_o(a_s_rdata),
    .s_axil_rresp_o(a_s_rresp), .s_axil_ruser_o(a_s_ruser),
    .s_axil_rvalid_o(a_s_rvalid), .s_axil_rready_i(s_rready),
    .m_axil_araddr_o(a_m_araddr), .m_axil_arprot_o(a_m_arprot),
    .m_axil_aruser_o(a_m_aruser), .m_axil_arvalid_o(a_m_arvalid),
    .m_axil_arready_i(m_arready), .m_axil_rdata_i(m_rdata),
    .m_axil_rresp_i(m_rresp), .m_axil_ruser_i(m_ruser),
    .m_axil_rvalid_i(m_rvalid), .m_axil_rready_o(a_m_rready),
    .busy_o(a_busy), .grant_idx_o(a_grant)
  );

  taxi_axil_rd_arb #(
    .S_COUNT(4), .ARB_ROUND_ROBIN(0), .ARB_LSB_HIGH_PRIORITY(1),
    .S_ARUSER_EN(1), .M_ARUSER_EN(1), .ARUSER_W(4),
    .S_RUSER_EN(1), .M_RUSER_EN(1), .RUSER_W(4)
  ) dut_f (
    .clk(clk), .rst_n(rst_n),
    .s_axil_araddr_i(s_araddr), .s_axil_arprot_i(s_arprot),
    .s_axil_aruser_i(s_aruser), .s_axil_arvalid_i(s_arvalid),
    .s_axil_arready_o(f_s_arready), .s_axil_rdata_o(f_s_rdata),
    .s_axil_rresp_o(f_s_rresp), .s_axil_ruser_o(f_s_ruser),
    .s_axil_rvalid_o(f_s_rvalid), .s_axil_rready_i(s_rready),
    .m_axil_araddr_o(f_m_araddr), .m_axil_arprot_o(f_m_arprot),
    .m_axil_aruser_o(f_m_aruser), .m_axil_arvalid_o(f_m_arvalid),
    .m_axil_arready_i(m_arready), .m_axil_rdata_i(m_rdata),
    .m_axil_rresp_i(m_rresp), .m_axil_ruser_i(m_ruser),
    .m_axil_rvalid_i(m_rvalid), .m_axil_rready_o(f_m_rready),
    .busy_o(f_busy), .grant_idx_o(f_grant)
  );

  taxi_axil_rd_arb #(
    .S_COUNT(4), .ARB_ROUND_ROBIN(0), .ARB_LSB_HIGH_PRIORITY(0),
    .ARUSER_W(4), .RUSER_W(4)
  ) dut_g (
    .clk(clk), .rst_n(rst_n),
    .s_axil_araddr_i(s_araddr), .s_axil_arprot_i(s_arprot),
    .s_axil_aruser_i(s_aruser), .s_axil_arvalid_i(s_arvalid),
    .s_axil_arready_o(g_s_arready), .s_axil_rdata_o(g_s_rdata),
    .s_axil_rresp_o(g_s_rresp), .s_axil_ruser_o(g_s_ruser),
    .s_axil_rvalid_o(g_s_rvalid), .s_axil_rready_i(s_rready),
    .m_axil_araddr_o(g_m_araddr), .m_axil_arprot_o(g_m_arprot),
    .m_axil_aruser_o(g_m_aruser), .m_axil_arvalid_o(g_m_arvalid),
    .m_axil_arready_i(m_arready), .m_axil_rdata_i(m_rdata),
    .m_axil_rresp_i(m_rresp), .m_axil_ruser_i(m_ruser),
    .m_axil_rvalid_i(m_rvalid), .m_axil_rready_o(g_m_rready),
    .busy_o(g_busy), .grant_idx_o(g_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int last_c;
    int e;

    rst_n     = 1'b0;
    s_araddr  = '0;
    s_arprot  = '0;
    s_aruser  = '0;
    s_arvalid = '0;
    s_rready  = 4'hF;
    m_arready = 1'b0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_ruser   = '0;
    m_rvalid  = 1'b0;

    // Reset state
    #12;
    chk("rst_busy", a_busy, 0);
    chk("rst_grant", a_grant, 0);
    chk("rst_m_arvalid", a_m_arvalid, 0);
    chk("rst_m_rready", a_m_rready, 0);
    chk("rst_s_arready", a_s_arready, 0);
    chk("rst_s_rvalid", a_s_rvalid, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single request from port 2
    s_araddr[64 +: 32] = 32'h40;
    s_arprot[6 +: 3]   = 3'h2;
    s_aruser[8 +: 4]   = 4'h5;
    s_arvalid          = 4'b0100;
    #1;
    chk("t1_arready", a_s_arready, 4'b0100);
    chk("t1_busy_idle", a_busy, 0);
    tick();
    s_arvalid = '0;
    m_arready = 1'b1;
    #1;
    chk("t1_m_arvalid", a_m_arvalid, 1);
    chk("t1_m_araddr", a_m_araddr, 32'h40);
    chk("t1_m_arprot", a_m_arprot, 3'h2);
    chk("t1_aruser_gated", a_m_aruser, 0);
    chk("t1_aruser_fwd", f_m_aruser, 4'h5);
    chk("t1_grant", a_grant, 2);
    chk("t1_busy", a_busy, 1);
    chk("t1_arready_ar", a_s_arready, 0);
    tick();
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    m_rdata   = 32'hDEADBEEF;
    m_rresp   = 2'd0;
    m_ruser   = 4'hA;
    #1;
    chk("t1_s_rvalid", a_s_rvalid, 4'b0100);
    chk("t1_m_rready", a_m_rready, 1);
    chk("t1_rdata2", a_s_rdata[64 +: 32], 32'hDEADBEEF);
    chk("t1_rdata0", a_s_rdata[0 +: 32], 32'hDEADBEEF);
    chk("t1_rresp", a_s_rresp, 0);
    chk("t1_ruser_gated", a_s_ruser, 0);
    chk("t1_ruser_fwd", f_s_ruser[8 +: 4], 4'hA);
    tick();
    m_rvalid = 1'b0;
    #1;
    chk("t1_busy_end", a_busy, 0);
    chk("t1_grant_hold", a_grant, 2);
    chk("t1_s_rvalid_end", a_s_rvalid, 0);

    // Backpressure: port 1, downstream arready low for 5 cycles
    s_araddr[32 +: 32] = 32'h80;
    s_arvalid          = 4'b0010;
    #1;
    chk("t2_arready", a_s_arready, 4'b0010);
    tick();
    s_arvalid = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_hold_arvalid", a_m_arvalid, 1);
      chk("t2_hold_araddr", a_m_araddr, 32'h80);
      tick();
    end
    m_arready = 1'b1;
    #1;
    chk("t2_arvalid_last", a_m_arvalid, 1);
    tick();
    m_arready = 1'b0;
    s_rready  = 4'b1101;
    m_rvalid  = 1'b1;
    m_rdata   = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_rready_low", a_m_rready, 0);
      chk("t2_s_rvalid", a_s_rvalid, 4'b0010);
      chk("t2_busy_r", a_busy, 1);
      tick();
    end
    s_rready = 4'hF;
    #1;
    chk("t2_rready_high", a_m_rready, 1);
    tick();
    #1;
    chk("t2_busy_end", a_busy, 0);
    chk("t2_no_second_r", a_m_rready, 0);
    m_rvalid = 1'b0;

    // Reset while in R
    s_araddr[96 +: 32] = 32'hC0;
    s_arvalid          = 4'b1000;
    #1;
    chk("t3_arready", a_s_arready, 4'b1000);
    tick();
    s_arvalid = '0;
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    #1;
    chk("t3_pre_rvalid", a_s_rvalid, 4'b1000);
    rst_n = 1'b0;
    #1;
    chk("t3_rst_busy", a_busy, 0);
    chk("t3_rst_m_arvalid", a_m_arvalid, 0);
    chk("t3_rst_m_rready", a_m_rready, 0);
    chk("t3_rst_s_rvalid", a_s_rvalid, 0);
    chk("t3_rst_s_arready", a_s_arready, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t3_stale_rready", a_m_rready, 0);
    s_araddr[0 +: 32] = 32'h10;
    s_arvalid         = 4'b0101;
    #1;
    chk("t3_ptr0_arready", a_s_arready, 4'b0001);
    tick();
    s_arvalid = '0;
    m_arready = 1'b1;
    #1;
    chk("t3_grant0", a_grant, 0);
    chk("t3_araddr", a_m_araddr, 32'h10);
    tick();
    m_arready = 1'b0;
    tick();
    m_rvalid = 1'b0;

    // Round-robin fairness, zero-wait downstream, fresh pointer
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) s_araddr[i*32 +: 32] = 32'h100 + i * 4;
    for (int k = 0; k < 8; k++) q_rr.push_back(k % 4);
    s_arvalid = 4'hF;
    m_arready = 1'b1;
    m_rvalid  = 1'b1;
    s_rready  = 4'hF;
    last_c    = -1;
    for (int c = 0; c < 40 && q_rr.size() > 0; c++) begin
      #1;
      if (a_m_arvalid) begin
        e = q_rr.pop_front();
        chk("rr_grant", a_grant, e);
        chk("rr_araddr", a_m_araddr, 32'h100 + e * 4);
        if (last_c >= 0) chk("rr_period", c - last_c, 3);
        last_c = c;
      end
      tick();
    end
    chk("rr_all_served", q_rr.size(), 0);

    // Drain every instance back to IDLE
    s_arvalid = '0;
    for (int i = 0; i < 4; i++) tick();
    #1;
    chk("drain_f_busy", f_busy, 0);
    chk("drain_g_busy", g_busy, 0);

    // Fixed priority: ports 1 and 3 request continuously
    for (int k = 0; k < 4; k++) begin
      q_f.push_back(1);
      q_g.push_back(3);
    end
    s_arvalid = 4'b1010;
    for (int c = 0; c < 40 && (q_f.size() > 0 || q_g.size() > 0); c++) begin
      #1;
      if (f_m_arvalid && q_f.size() > 0) begin
        e = q_f.pop_front();
        chk("fp_lsb_grant", f_grant, e);
      end
      if (g_m_arvalid && q_g.size() > 0) begin
        e = q_g.pop_front();
        chk("fp_msb_grant", g_grant, e);
      end
      tick();
    end
    chk("fp_lsb_served", q_f.size(), 0);
    chk("fp_msb_served", q_g.size(), 0);

    s_arvalid = '0;
    m_rvalid  = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/taxi_axil_rd_arb.md
Name: taxi_axil_rd_arb

Overview:
- S_COUNT-to-1 AXI4-lite read arbiter. Several AXI-lite read masters share one downstream AXI-lite read port, such as a CSR bus or an interconnect leg.
- One read transaction is in flight at a time, as AXI-lite permits.
- Grants are round-robin or fixed-priority.
- The AR channel is registered toward the master side. The R channel is routed back to the granted requester only.

Parameters:
- S_COUNT, 4, number of upstream read interfaces (1..16).
- ARB_ROUND_ROBIN, 1, 1 selects round-robin; 0 selects fixed priority.
- ARB_LSB_HIGH_PRIORITY, 1, sets the tie-break order and the fixed-priority order. 1 means the lowest index wins.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_axil_rd  taxi_axil_if.rd_slv  array[S_COUNT]  upstream read interfaces.
- m_axil_rd  taxi_axil_if.rd_mst  1  downstream shared read interface.
- busy  out  1  high while a grant is held (states AR or R).
- grant_idx  out  $clog2(S_COUNT) (min 1)  index of the current or last grant.

Behaviour:
- Configuration checks (elaboration $fatal):
  - DATA_W, ADDR_W and STRB_W must match across all s_axil_rd and m_axil_rd.
  - ARUSER and RUSER are forwarded only if enabled on both sides; otherwise they are driven '0.
- Reset (rst_n low, async):
  - state=IDLE, busy=0, grant_idx=0.
  - m_axil_rd.arvalid=0, m_axil_rd.rready=0.
  - All s arready=0 and all s rvalid=0.
  - Round-robin pointer = 0.
  - AR holding registers cleared to 0.
  - A transaction in flight is abandoned. A downstream rvalid arriving after reset is not accepted (rready=0 in IDLE).
- State machine IDLE -> AR -> R -> IDLE:
  - IDLE: the request vector is the set of s arvalid. If any bit is set:
    - Select a winner: round-robin takes the first requester at or after the pointer in priority order; fixed priority ignores the pointer.
    - Assert s arready[winner]=1 combinationally this cycle only, accepting the AR handshake.
    - Latch araddr, arprot and aruser into holding registers; set grant_idx=winner.
    - Go to AR. busy=1 from the next cycle.
    - If no request, stay in IDLE with all arready=0.
  - AR: m arvalid=1 with the held fields, stable until m arready.
    - On m arvalid&&arready, go to R.
    - All s arready=0 in AR and R.
  - R:
    - m rready = s rready[grant_idx].
    - s rvalid[grant_idx] = m rvalid; every other s rvalid=0.
    - On m rvalid&&rready, go to IDLE. In round-robin mode, the pointer becomes grant_idx+1 modulo S_COUNT (the next index in priority direction).
- rdata, rresp and ruser are broadcast to all s interfaces. Only rvalid is gated.
- Latency:
  - The AR handshake upstream occurs in the cycle arvalid is seen in IDLE.
  - m arvalid rises 1 cycle later.
  - Minimum period for back-to-back transactions is 3 cycles: IDLE, AR with immediate arready, R with immediate rvalid.
- A requester that is not granted keeps arvalid high with stable fields, per AXI. The block must not depend on arvalid staying high after the handshake.
- A requester deasserting arvalid before being granted (protocol violation) is simply not selected; no state is affected.
- S_COUNT=1: degenerates to a registered pass-through with identical sequencing.
- grant_idx holds its value in IDLE until the next grant.

Test Plan:
- Single request: port 2 issues araddr=0x40 with S_COUNT=4.
  - Required: s2 arready pulses in cycle 0; m arvalid=1 with araddr=0x40 in cycle 1.
  - Downstream returns rdata=0xDEADBEEF, rresp=0. Required: only s2 rvalid rises; grant_idx=2; busy falls after the R handshake.
- Round-robin fairness: ports 0-3 all hold arvalid continuously with zero-wait downstream.
  - Required: grant order 0,1,2,3,0,1…
  - Required: each transaction takes exactly 3 cycles.
- Fixed priority (ARB_ROUND_ROBIN=0): ports 1 and 3 both request continuously.
  - Required: port 1 is served every time and port 3 starves.
  - With ARB_LSB_HIGH_PRIORITY=0, port 3 is served every time instead.
- Backpressure:
  - Downstream holds arready=0 for 5 cycles. Required: m arvalid and araddr stay stable throughout.
  - Upstream holds rready=0 for 4 cycles while downstream rvalid=1. Required: m rready=0 throughout and no state change; then a single R handshake.
- Reset mid-transaction: assert rst_n=0 while in R.
  - Required: busy, m arvalid, m rready and all s rvalid/arready go to 0 asynchronously.
  - Required: after release, the pointer is 0 and a new request from port 0 is granted first.
- USER gating: ARUSER_EN=1 on s, 0 on m.
  - Required: m aruser=0 regardless of s aruser.
  - RUSER is gated likewise.
